fir_sym_mac: RTL and testbench
==============================

// Module: fir_sym_mac
// PURPOSE
//  Parametrised symmetric (linear-phase) FIR filter with a single time-shared multiplier.
//  Odd tap count; pre-adds mirrored taps; valid/ready on both sides.
//  Result is rounded, saturated and flagged on overflow. Runtime coefficient bank is optional.
//  Sits between the sample source and downstream DSP in the fir_test datapath.
// PARAMETERS
//  DW        32   signed sample width (in_data/out_data)
//  CW        32   signed coefficient width
//  NTAPS     9    tap count, odd, 3..63; NU=(NTAPS+1)/2 unique coefs
//  COEF_FRAC 31   coefficient fraction bits (result >> COEF_FRAC)
//  COEFFS    {32'h4576BDA5,32'h27EDC865,32'hF7E3ED6A,32'hE8AE5E05,32'h0560B3C3}
//            NU*CW bits; coef k at [k*CW +: CW]; k=0 outermost tap, k=NU-1 centre
// PORTS
//  fclk        in   1          clock
//  reset       in   1          reset, asynchronous, active-high
//  clr         in   1          sync flush: zero delay line, abort computation
//  in_valid    in   1          input sample valid
//  in_ready    out  1          block accepts sample
//  in_data     in   DW         signed input sample
//  out_valid   out  1          output sample valid
//  out_ready   in   1          downstream accepts output
//  out_data    out  DW         signed filtered sample
//  out_sat     out  1          out_data was clipped (qualified by out_valid)
//  coef_we     in   1          [FIR_COEF_WR_EN] write shadow coef
//  coef_addr   in   clog2(NU)  [FIR_COEF_WR_EN] shadow index k
//  coef_data   in   CW         [FIR_COEF_WR_EN] signed coef value
//  coef_commit in   1          [FIR_COEF_WR_EN] request shadow->active copy
//  coef_busy   out  1          [FIR_COEF_WR_EN] commit pending
// BEHAVIOUR
//  - Reset: state IDLE, delay line 0, accumulator 0.
//    Outputs: out_valid=0, out_data=0, out_sat=0, coef_busy=0, in_ready=1.
//    Active and shadow coef banks load from COEFFS.
//  - FSM IDLE->MAC->ROUND->OUT->IDLE.
//  - IDLE: in_ready = 1 & ~clr. On handshake (cycle T): shift in_data into x[0], x[i]<=x[i-1].
//    Clear the accumulator, then go to MAC.
//  - MAC: NU cycles (T+1..T+NU), k=0..NU-1.
//    acc += (x[k]+x[NTAPS-1-k]) * c[k]; centre k=NU-1 uses x[k] alone.
//    Pre-add is DW+1 bits; ACCW = DW+CW+1+clog2(NU); all arithmetic signed, no wrap.
//  - ROUND (T+NU+1): r = (acc + 2^(COEF_FRAC-1)) >>> COEF_FRAC (no add if COEF_FRAC=0).
//    Saturate r to [-2^(DW-1), 2^(DW-1)-1]; out_sat=1 if clipped. Register out_data/out_sat.
//  - OUT: out_valid=1 from T+NU+2; out_data/out_sat stable while out_valid & ~out_ready.
//    The out_valid&out_ready cycle -> IDLE, out_valid=0 next cycle.
//  - Latency: in handshake to out_valid = NU+2 cycles. Minimum spacing between accepts = NU+3 cycles.
//  - in_ready=0 in MAC/ROUND/OUT; in_valid held by source is not consumed.
//  - clr (any state): delay line zeroed, acc zeroed, out_valid=0 next cycle, state->IDLE.
//    A pending result is discarded. clr wins over simultaneous in_valid (no accept).
//  - Async reset mid-computation: immediate return to reset values; nothing retained.
// CONFIGURATION
//  - FIR_COEF_WR_EN defined:
//    * coef_* ports present; coef_we writes the shadow bank in any state.
//    * coef_commit sets coef_busy. Copy shadow->active on the first cycle the state is IDLE
//      with no accept that cycle; coef_busy clears the next cycle.
//    * Active coefs never change during MAC. Commit with simultaneous clr still completes.
//  - FIR_COEF_WR_EN undefined: coef_* ports absent; active bank is constant COEFFS.
//    No shadow registers are built.
// TESTING (defaults NTAPS=9, DW=CW=32, COEF_FRAC=31)
//  1 Impulse: 0x40000000, then 8 zeros, out_ready=1.
//    -> outputs 0x02B059E2, 0xF4572F03, 0xFBF1F6B5, 0x13F6E433, 0x22BB5ED3,
//       0x13F6E433, 0xFBF1F6B5, 0xF4572F03, 0x02B059E2.
//  2 Timing: single accept at cycle T -> out_valid high at T+7; in_ready low T+1..T+7.
//    in_ready high again the cycle after out handshake.
//  3 Backpressure: out_ready=0 for 10 cycles -> out_valid/out_data/out_sat stable.
//    in_ready=0 throughout; in_valid not consumed.
//  4 clr in MAC (T+3) -> no out_valid for that sample; next impulse reproduces scenario 1
//    (delay line flushed).
//  5 [FIR_COEF_WR_EN] write all k=0x7FFFFFFF, commit, feed 9x 0x7FFFFFFF
//    -> out_data=0x7FFFFFFF, out_sat=1.
//    Feed 9x 0x80000000 -> out_data=0x80000000, out_sat=1.
//  6 [FIR_COEF_WR_EN] commit asserted during MAC -> coef_busy=1 until IDLE.
//    Current sample uses old coefs; next sample uses new coefs.

Source files
------------

// File: rtl/fir_sym_mac.sv
// Symmetric odd-tap FIR with one time-shared multiplier and mirrored-tap pre-add.
// Define FIR_COEF_WR_EN to add the runtime shadow coefficient bank and commit port.
module fir_sym_mac #(
  parameter int unsigned DW        = 32,
  parameter int unsigned CW        = 32,
  parameter int unsigned NTAPS     = 9,
  parameter int unsigned COEF_FRAC = 31,
  parameter logic [((NTAPS+1)/2)*CW-1:0] COEFFS =
    {32'h4576BDA5, 32'h27EDC865, 32'hF7E3ED6A, 32'hE8AE5E05, 32'h0560B3C3}
) (
  input  logic                                 fclk,
  input  logic                                 reset,
  input  logic                                 clr,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DW-1:0]                        in_data,
`ifdef FIR_COEF_WR_EN
  input  logic                                 coef_we,
  input  logic [$clog2((NTAPS+1)/2)-1:0]       coef_addr,
  input  logic [CW-1:0]                        coef_data,
  input  logic                                 coef_commit,
  output logic                                 coef_busy,
`endif
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DW-1:0]                        out_data,
  output logic                                 out_sat
);

  localparam int unsigned NU   = (NTAPS + 1) / 2;
  localparam int unsigned KW   = $clog2(NU);
  localparam int unsigned PW   = DW + CW + 1;
  localparam int unsigned ACCW = PW + KW;
  localparam logic [ACCW-1:0] RND = (ACCW'(1) << COEF_FRAC) >> 1;

  typedef enum logic [1:0] {StIdle, StMac, StRound, StOut} state_e;

  state_e                      r_state, w_state_next;
  logic [NTAPS-1:0][DW-1:0]    r_x;
  logic signed [ACCW-1:0]      r_acc;
  logic [KW-1:0]               r_k;
  logic [DW-1:0]               r_out;
  logic                        r_sat;
  logic [NU*CW-1:0]            w_coef;
  logic                        w_accept;
  logic signed [DW-1:0]        w_xa, w_xb;
  logic signed [CW-1:0]        w_c;
  logic signed [DW:0]          w_pre;
  logic signed [PW-1:0]        w_prod;
  logic signed [ACCW-1:0]      w_prod_ext, w_rsum, w_shift;
  logic                        w_fits;
  logic [DW-1:0]               w_res;

  assign w_accept = in_valid & in_ready;

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StMac;
      StMac:   if (r_k == KW'(NU - 1)) w_state_next = StRound;
      StRound: w_state_next = StOut;
      StOut:   if (out_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (clr) w_state_next = StIdle;
  end

  always_comb begin
    in_ready  = (r_state == StIdle) & ~clr;
    out_valid = (r_state == StOut);
  end

  // Tap selection: centre tap has no mirror partner.
  always_comb begin
    w_xa = '0;
    w_xb = '0;
    w_c  = '0;
    for (int k = 0; k < NU; k++) begin
      if (r_k == KW'(k)) begin
        w_xa = r_x[k];
        w_c  = w_coef[k*CW +: CW];
        if (k != NU - 1) w_xb = r_x[NTAPS-1-k];
      end
    end
  end

  assign w_pre      = {w_xa[DW-1], w_xa} + {w_xb[DW-1], w_xb};
  assign w_prod     = w_pre * w_c;
  assign w_prod_ext = {{(ACCW-PW){w_prod[PW-1]}}, w_prod};
  assign w_rsum     = r_acc + $signed(RND);
  assign w_shift    = w_rsum >>> COEF_FRAC;
  assign w_fits     = (w_shift[ACCW-1:DW-1] == '0) || (w_shift[ACCW-1:DW-1] == '1);
  assign w_res      = w_fits ? w_shift[DW-1:0] :
                      (w_shift[ACCW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}});

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      r_x   <= '0;
      r_acc <= '0;
      r_k   <= '0;
      r_out <= '0;
      r_sat <= 1'b0;
    end else if (clr) begin
      r_x   <= '0;
      r_acc <= '0;
      r_k   <= '0;
    end else begin
      if (w_accept) begin
        r_x   <= {r_x[NTAPS-2:0], in_data};
        r_acc <= '0;
        r_k   <= '0;
      end
      if (r_state == StMac) begin
        r_acc <= r_acc + w_prod_ext;
        r_k   <= r_k + KW'(1);
      end
      if (r_state == StRound) begin
        r_out <= w_res;
        r_sat <= ~w_fits;
      end
    end
  end

  assign out_data = r_out;
  assign out_sat  = r_sat;

`ifdef FIR_COEF_WR_EN
  logic [NU*CW-1:0] r_coef, r_shadow;
  logic             r_busy;
  logic             w_copy;

  // Copy only from IDLE without an accept, so the active bank is frozen through MAC.
  assign w_copy = r_busy && (r_state == StIdle) && !w_accept;

  always_ff @(posedge fclk or posedge reset) begin
    if (reset) begin
      r_coef   <= COEFFS;
      r_shadow <= COEFFS;
      r_busy   <= 1'b0;
    end else begin
      for (int k = 0; k < NU; k++) begin
        if (coef_we && (coef_addr == KW'(k))) r_shadow[k*CW +: CW] <= coef_data;
      end
      if (w_copy) r_coef <= r_shadow;
      if (coef_commit)  r_busy <= 1'b1;
      else if (w_copy)  r_busy <= 1'b0;
    end
  end

  assign w_coef    = r_coef;
  assign coef_busy = r_busy;
`else
  assign w_coef = COEFFS;
`endif

endmodule

// File: tb/tb_fir_sym_mac.sv
// Self-checking bench for fir_sym_mac: impulse table, random samples against a
// convolution model, timing, backpressure, clr, async reset and (if enabled) coef bank.
module tb_fir_sym_mac;

  logic        fclk = 1'b0;
  logic        reset, clr, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [31:0] in_data, out_data;
`ifdef FIR_COEF_WR_EN
  logic        coef_we, coef_commit, coef_busy;
  logic [2:0]  coef_addr;
  logic [31:0] coef_data;
`endif

  always #5 fclk = ~fclk;

  fir_sym_mac dut (
    .fclk        (fclk),
    .reset       (reset),
    .clr         (clr),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
`ifdef FIR_COEF_WR_EN
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_commit (coef_commit),
    .coef_busy   (coef_busy),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sat     (out_sat)
  );

  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;

  vec_t               tbl[9];
  int                 n_checks = 0;
  int                 n_errors = 0;
  logic signed [31:0] hist[9];
  logic signed [31:0] mc[5];
  logic signed [31:0] ms[5];
  logic [159:0]       cv;
  logic [31:0]        exp_d;
  logic               exp_s;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Reference: direct convolution with the mirrored impulse response h[i] = c[min(i, 8-i)].
  function automatic void model_eval(output logic [31:0] y, output logic s);
    logic signed [127:0] acc, r;
    int kk;
    acc = '0;
    for (int i = 0; i < 9; i++) begin
      kk  = (i < 8 - i) ? i : 8 - i;
      acc = acc + hist[i] * mc[kk];
    end
    r = (acc + (128'sd1 <<< 30)) >>> 31;
    if (r > 128'sd2147483647) begin
      y = 32'h7FFFFFFF; s = 1'b1;
    end else if (r < -128'sd2147483648) begin
      y = 32'h80000000; s = 1'b1;
    end else begin
      y = r[31:0]; s = 1'b0;
    end
  endfunction

  task automatic model_push(input logic [31:0] d);
    for (int i = 8; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = d;
    model_eval(exp_d, exp_s);
  endtask

  task automatic model_flush();
    for (int i = 0; i < 9; i++) hist[i] = '0;
  endtask

  task automatic model_reset();
    model_flush();
    for (int k = 0; k < 5; k++) begin
      mc[k] = cv[k*32 +: 32];
      ms[k] = cv[k*32 +: 32];
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after the accept.
  task automatic send(input logic [31:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 30) begin
      @(negedge fclk);
      n++;
    end
    if (!in_ready) begin
      fail_now("send_accept");
      in_valid = 1'b0;
      return;
    end
    @(posedge fclk);
    model_push(d);
    @(negedge fclk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 20) begin
      @(negedge fclk);
      lat++;
    end
    if (!out_valid) fail_now("wait_out_valid");
  endtask

  task automatic run_sample(input logic [31:0] d, output logic [31:0] od, output logic os);
    int lat;
    send(d);
    wait_out(1, lat);
    check("latency", 32'(lat), 32'd7);
    check("out_data_model", out_data, exp_d);
    check("out_sat_model", 32'(out_sat), 32'(exp_s));
    od = out_data;
    os = out_sat;
    @(negedge fclk);
  endtask

  task automatic run_impulse(input string tag);
    logic [31:0] od;
    logic        os;
    for (int i = 0; i < 9; i++) begin
      run_sample(tbl[i].din, od, os);
      check({tag, "_table"}, od, tbl[i].dout);
      check({tag, "_sat"}, 32'(os), 32'd0);
    end
  endtask

`ifdef FIR_COEF_WR_EN
  task automatic wr_coef(input int k, input logic [31:0] v);
    coef_we   = 1'b1;
    coef_addr = 3'(k);
    coef_data = v;
    @(negedge fclk);
    coef_we   = 1'b0;
    ms[k]     = v;
  endtask

  task automatic commit_idle();
    int n = 0;
    coef_commit = 1'b1;
    @(negedge fclk);
    coef_commit = 1'b0;
    check("busy_after_commit", 32'(coef_busy), 32'd1);
    while (coef_busy && n < 10) begin
      @(negedge fclk);
      n++;
    end
    check("busy_clear_cycles", 32'(n), 32'd1);
    for (int k = 0; k < 5; k++) mc[k] = ms[k];
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] od;
    logic        os;
    int          lat;

    tbl[0] = '{32'h40000000, 32'h02B059E2};
    tbl[1] = '{32'h00000000, 32'hF4572F03};
    tbl[2] = '{32'h00000000, 32'hFBF1F6B5};
    tbl[3] = '{32'h00000000, 32'h13F6E433};
    tbl[4] = '{32'h00000000, 32'h22BB5ED3};
    tbl[5] = '{32'h00000000, 32'h13F6E433};
    tbl[6] = '{32'h00000000, 32'hFBF1F6B5};
    tbl[7] = '{32'h00000000, 32'hF4572F03};
    tbl[8] = '{32'h00000000, 32'h02B059E2};
    cv = {32'h4576BDA5, 32'h27EDC865, 32'hF7E3ED6A, 32'hE8AE5E05, 32'h0560B3C3};
    model_reset();

    reset = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef FIR_COEF_WR_EN
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; coef_commit = 1'b0;
`endif
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_sat", 32'(out_sat), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef FIR_COEF_WR_EN
    check("rst_coef_busy", 32'(coef_busy), 32'd0);
`endif
    @(negedge fclk);
    reset = 1'b0;
    @(negedge fclk);

    run_impulse("impulse1");

    // Cycle-exact timing of one sample.
    in_valid = 1'b1;
    in_data  = $urandom;
    check("tim_in_ready_T", 32'(in_ready), 32'd1);
    @(posedge fclk);
    model_push(in_data);
    for (int j = 1; j <= 7; j++) begin
      @(negedge fclk);
      in_valid = 1'b0;
      check("tim_in_ready_busy", 32'(in_ready), 32'd0);
      check("tim_out_valid", 32'(out_valid), 32'(j == 7));
    end
    check("tim_out_data", out_data, exp_d);
    @(negedge fclk);
    check("tim_in_ready_back", 32'(in_ready), 32'd1);
    check("tim_out_valid_low", 32'(out_valid), 32'd0);

    for (int i = 0; i < 16; i++) run_sample($urandom, od, os);

    // Output backpressure with a held input.
    out_ready = 1'b0;
    send($urandom);
    wait_out(1, lat);
    check("bp_latency", 32'(lat), 32'd7);
    in_valid = 1'b1;
    in_data  = $urandom;
    for (int j = 0; j < 10; j++) begin
      @(negedge fclk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", out_data, exp_d);
      check("bp_out_sat", 32'(out_sat), 32'(exp_s));
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge fclk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    run_sample($urandom, od, os);

    // clr during MAC discards the result and flushes the delay line.
    send(32'h12345678);
    @(negedge fclk);
    @(negedge fclk);
    clr = 1'b1;
    @(negedge fclk);
    clr = 1'b0;
    model_flush();
    for (int j = 0; j < 10; j++) begin
      check("clr_no_out", 32'(out_valid), 32'd0);
      @(negedge fclk);
    end
    run_impulse("impulse2");

    // clr in IDLE beats a simultaneous in_valid.
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h7654321F;
    #1;
    check("clr_idle_in_ready", 32'(in_ready), 32'd0);
    @(posedge fclk);
    @(negedge fclk);
    clr      = 1'b0;
    in_valid = 1'b0;
    model_flush();
    #1;
    check("clr_idle_no_out", 32'(out_valid), 32'd0);
    check("clr_idle_ready", 32'(in_ready), 32'd1);
    @(negedge fclk);
    run_sample($urandom, od, os);

`ifdef FIR_COEF_WR_EN
    for (int k = 0; k < 5; k++) wr_coef(k, 32'h7FFFFFFF);
    commit_idle();
    for (int i = 0; i < 9; i++) run_sample(32'h7FFFFFFF, od, os);
    check("sat_pos_data", od, 32'h7FFFFFFF);
    check("sat_pos_flag", 32'(os), 32'd1);
    for (int i = 0; i < 9; i++) run_sample(32'h80000000, od, os);
    check("sat_neg_data", od, 32'h80000000);
    check("sat_neg_flag", 32'(os), 32'd1);

    // Commit during MAC: current sample keeps old coefs.
    for (int k = 0; k < 5; k++) wr_coef(k, $urandom & 32'h1FFFFFFF);
    send($urandom);
    @(negedge fclk);
    coef_commit = 1'b1;
    @(negedge fclk);
    coef_commit = 1'b0;
    check("mac_commit_busy", 32'(coef_busy), 32'd1);
    wait_out(3, lat);
    check("mac_commit_latency", 32'(lat), 32'd7);
    check("mac_commit_old_coef", out_data, exp_d);
    check("mac_commit_busy_out", 32'(coef_busy), 32'd1);
    @(negedge fclk);
    check("mac_commit_busy_idle", 32'(coef_busy), 32'd1);
    @(negedge fclk);
    check("mac_commit_busy_clear", 32'(coef_busy), 32'd0);
    for (int k = 0; k < 5; k++) mc[k] = ms[k];
    for (int i = 0; i < 4; i++) run_sample($urandom, od, os);
`endif

    // Async reset mid-computation.
    send($urandom);
    @(negedge fclk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_data", out_data, 32'd0);
    check("arst_out_sat", 32'(out_sat), 32'd0);
`ifdef FIR_COEF_WR_EN
    check("arst_coef_busy", 32'(coef_busy), 32'd0);
`endif
    @(negedge fclk);
    reset = 1'b0;
    model_reset();
    @(negedge fclk);
    check("arst_no_out", 32'(out_valid), 32'd0);
    run_impulse("impulse3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
